uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Schedules the UART transmit path among three byte sources: single-byte status/response, SD read-data stream, and the 128-bit CID register dump.
- Sits between the host-side producers and the UART transmitter. Drives one byte at a time through a start/busy handshake.
- Holds a grant for the full duration of a burst.

Parameters:
- BUSY_TIMEOUT, 16'd1024: ex_clk cycles to wait for uart_tx_busy to rise after a start before aborting.
- CID_BYTES, 16: number of bytes emitted from cid_reg per CID dump.

Ports:
- ex_clk input 1: system clock.
- reset input 1: asynchronous active-low reset.
- stat_req input 1: status byte pending (level).
- stat_data input 8: status byte.
- stat_ack output 1: one-cycle pulse, status byte taken.
- sd_req input 1: SD byte pending (level).
- sd_data input 8: SD byte.
- sd_last input 1: current SD byte ends the burst.
- sd_ack output 1: one-cycle pulse, SD byte taken.
- cid_req input 1: CID dump requested (level).
- cid_reg input 128: CID contents; must stay stable while cid_busy=1.
- cid_busy output 1: CID dump in progress.
- cid_done output 1: one-cycle pulse after the last CID byte completes.
- uart_tx_data output 8: byte to transmit.
- uart_tx_start output 1: one-cycle start pulse.
- uart_tx_busy input 1: transmitter shifting (already synchronous to ex_clk).
- grant output 2: current owner. 0 = none, 1 = status, 2 = CID, 3 = SD.
- tx_timeout output 1: sticky error flag; cleared by reset or by the next successful start.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte index 0, timeout counter 0. An asynchronous reset mid-burst abandons the burst; no ack/done is issued for the in-flight byte.
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO. A HDR state is added when the optional feature is compiled in.
- Arbitration happens in IDLE only. Fixed priority: status > CID > SD. The winner is registered into grant in the same cycle as the IDLE→LOAD transition.
- LOAD (1 cycle): latch the byte into uart_tx_data.
  - Status: stat_data; pulse stat_ack.
  - SD: sd_data; pulse sd_ack; capture sd_last internally.
  - CID: cid_reg[127-8*idx -: 8], i.e. MSB byte first.
- START (1 cycle): uart_tx_start=1; clear the timeout counter.
- WAIT_HI: wait for uart_tx_busy=1, then go to WAIT_LO.
  - The counter increments each cycle. On reaching BUSY_TIMEOUT: set tx_timeout, clear grant/cid_busy, go to IDLE. No cid_done is issued.
  - Busy=1 in the very cycle of START is ignored; sampling begins the cycle after START.
- WAIT_LO: wait for uart_tx_busy=0, then byte complete.
  - Status: go to IDLE, grant=0.
  - SD: if captured last=1, go to IDLE. Otherwise go to LOAD if sd_req=1, else stall in WAIT_LO with grant held until sd_req returns.
  - CID: if idx==CID_BYTES-1, idx wraps to 0, pulse cid_done, cid_busy=0, go to IDLE. Otherwise idx+1 and go to LOAD.
- cid_busy is 1 from LOAD of byte 0 through the cycle before cid_done.
- A new higher-priority request never pre-empts an active burst. It is served at the next IDLE.
- Simultaneous stat_req/cid_req/sd_req in IDLE: status wins. The others remain pending (level requests, no loss).
- Minimum per-byte overhead is 3 cycles plus the UART frame time. Back-to-back bursts have 1 IDLE cycle between them.
- uart_tx_data holds its value until the next LOAD.

Optional Feature:
- Macro: UART_TX_SCHED_HDR_EN.
- Defined: each grant starts with a header byte {4'hA, 2'b00, grant}, sent via the same START/WAIT_HI/WAIT_LO handshake before the first payload byte.
  - Path is IDLE→HDR→START…, and WAIT_LO after the header goes to LOAD.
  - No ack is issued for the header.
  - A timeout during the header aborts the grant; no source ack occurs.
- Undefined: no HDR state; payload only.

Test Plan:
- stat_req=1, stat_data=8'h5A; UART model raises busy 2 cycles after start, holds it 10 cycles → one start, uart_tx_data=8'h5A, one stat_ack, grant returns to 0.
- cid_req=1, cid_reg=128'h00112233_44556677_8899AABB_CCDDEEFF → 16 starts with bytes 00,11,…,FF in order; single cid_done after the 16th busy fall; cid_busy high throughout.
- SD burst of 4 bytes (sd_last on the 4th), stat_req asserted during byte 2 → SD bytes sent contiguously; status byte follows after IDLE; exactly 4 sd_ack and 1 stat_ack.
- All three requests in the same cycle → order status, then CID (16 bytes), then SD.
- UART model never raises busy, BUSY_TIMEOUT=8 → tx_timeout set 8 cycles after WAIT_HI entry, grant=0, no cid_done. The next successful start clears tx_timeout.
- Assert reset low during CID byte 5 → all outputs 0 asynchronously. After release with cid_req still high, the dump restarts at byte 0 (8'h00).

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/ack lines of the three byte sources plus the UART transmitter handshake.
// The master modport is the scheduler itself; the slave modport is the producers and transmitter around it.
interface uart_tx_sched_if;
  logic         stat_req;
  logic [7:0]   stat_data;
  logic         stat_ack;
  logic         sd_req;
  logic [7:0]   sd_data;
  logic         sd_last;
  logic         sd_ack;
  logic         cid_req;
  logic [127:0] cid_reg;
  logic         cid_busy;
  logic         cid_done;
  logic [7:0]   uart_tx_data;
  logic         uart_tx_start;
  logic         uart_tx_busy;
  logic [1:0]   grant;
  logic         tx_timeout;

  modport master (
    input  stat_req, stat_data, sd_req, sd_data, sd_last, cid_req, cid_reg, uart_tx_busy,
    output stat_ack, sd_ack, cid_busy, cid_done, uart_tx_data, uart_tx_start, grant, tx_timeout
  );

  modport slave (
    output stat_req, stat_data, sd_req, sd_data, sd_last, cid_req, cid_reg, uart_tx_busy,
    input  stat_ack, sd_ack, cid_busy, cid_done, uart_tx_data, uart_tx_start, grant, tx_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: fixed-priority (status > CID > SD) byte scheduler in front of a start/busy UART transmitter.
// Define UART_TX_SCHED_HDR_EN to prefix every grant with a header byte {4'hA, 2'b00, grant}.
module uart_tx_sched #(
  parameter logic [15:0] BUSY_TIMEOUT = 16'd1024,
  parameter int          CID_BYTES    = 16
) (
  input logic             ex_clk,
  input logic             reset,
  uart_tx_sched_if.master bus
);
  localparam int               IDX_W    = (CID_BYTES > 1) ? $clog2(CID_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CID_BYTES - 1);
  localparam logic [1:0] G_NONE = 2'd0, G_STAT = 2'd1, G_CID = 2'd2, G_SD = 2'd3;

`ifdef UART_TX_SCHED_HDR_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, HDR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             cid_busy_q, cid_busy_d;
  logic             cid_done_q, cid_done_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       cid_byte;
`ifdef UART_TX_SCHED_HDR_EN
  logic             hdr_q, hdr_d;
`endif

  // MSB byte of the CID register goes out first
  always_comb begin
    cid_byte = 8'h00;
    for (int i = 0; i < CID_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) cid_byte = bus.cid_reg[127-8*i -: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    data_d     = data_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    cid_busy_d = cid_busy_q;
    cid_done_d = 1'b0;
    timeout_d  = timeout_q;
`ifdef UART_TX_SCHED_HDR_EN
    hdr_d      = hdr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.stat_req)     grant_d = G_STAT;
        else if (bus.cid_req) grant_d = G_CID;
        else if (bus.sd_req)  grant_d = G_SD;
        if (bus.stat_req || bus.cid_req || bus.sd_req) begin
`ifdef UART_TX_SCHED_HDR_EN
          state_d = HDR;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef UART_TX_SCHED_HDR_EN
      HDR: begin
        data_d  = {4'hA, 2'b00, grant_q};
        hdr_d   = 1'b1;
        state_d = START;
      end
`endif
      LOAD: begin
        case (grant_q)
          G_STAT: data_d = bus.stat_data;
          G_SD: begin
            data_d = bus.sd_data;
            last_d = bus.sd_last;
          end
          default: data_d = cid_byte;
        endcase
        state_d = START;
      end
      START: begin
        cnt_d   = 16'd0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.uart_tx_busy) begin
          timeout_d = 1'b0;
          state_d   = WAIT_LO;
        end else begin
          cnt_d = cnt_q + 16'd1;
          // transmitter never answered: drop the whole grant, no ack/done
          if (cnt_d == BUSY_TIMEOUT) begin
            timeout_d  = 1'b1;
            grant_d    = G_NONE;
            cid_busy_d = 1'b0;
            idx_d      = '0;
            state_d    = IDLE;
`ifdef UART_TX_SCHED_HDR_EN
            hdr_d      = 1'b0;
`endif
          end
        end
      end
      WAIT_LO: begin
        if (!bus.uart_tx_busy) begin
`ifdef UART_TX_SCHED_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = LOAD;
          end else
`endif
          begin
            case (grant_q)
              G_SD: begin
                if (last_q) begin
                  grant_d = G_NONE;
                  state_d = IDLE;
                end else if (bus.sd_req) begin
                  state_d = LOAD;
                end
              end
              G_CID: begin
                if (idx_q == IDX_LAST) begin
                  idx_d      = '0;
                  cid_done_d = 1'b1;
                  cid_busy_d = 1'b0;
                  grant_d    = G_NONE;
                  state_d    = IDLE;
                end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = LOAD;
                end
              end
              default: begin
                grant_d = G_NONE;
                state_d = IDLE;
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD && grant_d == G_CID) cid_busy_d = 1'b1;
  end

  always_ff @(posedge ex_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= G_NONE;
      data_q     <= 8'h00;
      idx_q      <= '0;
      cnt_q      <= 16'd0;
      last_q     <= 1'b0;
      cid_busy_q <= 1'b0;
      cid_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      cid_busy_q <= cid_busy_d;
      cid_done_q <= cid_done_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef UART_TX_SCHED_HDR_EN
  always_ff @(posedge ex_clk or negedge reset) begin
    if (!reset) hdr_q <= 1'b0;
    else        hdr_q <= hdr_d;
  end
`endif

  assign bus.stat_ack      = (state_q == LOAD) && (grant_q == G_STAT);
  assign bus.sd_ack        = (state_q == LOAD) && (grant_q == G_SD);
  assign bus.uart_tx_start = (state_q == START);
  assign bus.uart_tx_data  = data_q;
  assign bus.grant         = grant_q;
  assign bus.cid_busy      = cid_busy_q;
  assign bus.cid_done      = cid_done_q;
  assign bus.tx_timeout    = timeout_q;
endmodule
